// File: rtl/ads8865_sampler.sv
// ads8865_sampler: periodic start generator and result capture for the ADS8865 serial driver.
// Define ADS8865_AVG_EN to box-car average 2^AVG_LOG2 accepted samples per output word.
module ads8865_sampler #(
    parameter int BITS     = 16,
    parameter int PERIOD   = 1000,
    parameter int AVG_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            adc_start,
    input  logic            adc_busy,
    input  logic [BITS-1:0] adc_data,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun
);
    localparam int CW = $clog2(PERIOD + 1);

    typedef enum logic [1:0] {IDLE, START, CAPTURE, WAIT_LO} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] data_q, data_d, word;
    logic            start_q, start_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            prime_q, prime_d;
    logic            tick, take, load;

    if (PERIOD < 2 || AVG_LOG2 < 1) begin : g_bad_cfg
        $error("ads8865_sampler: PERIOD must be >= 2 and AVG_LOG2 >= 1");
    end

    assign tick = en && cnt_q == CW'(PERIOD - 1);
    // The word latched on a start belongs to the previous conversion, so the first one after enable is stale.
    assign take = state_q == CAPTURE && en && !prime_q;

`ifdef ADS8865_AVG_EN
    localparam int AW = BITS + AVG_LOG2;

    logic [AW-1:0]       acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] num_q, num_d;
    logic                last;

    always_comb begin
        sum   = acc_q + AW'(adc_data);
        last  = num_q == '1;
        load  = take && last;
        word  = BITS'(sum >> AVG_LOG2);
        acc_d = !en ? '0 : take ? (last ? '0 : sum) : acc_q;
        num_d = !en ? '0 : take ? num_q + 1'b1 : num_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            num_q <= '0;
        end else begin
            acc_q <= acc_d;
            num_q <= num_d;
        end
    end
`else
    always_comb begin
        load = take;
        word = adc_data;
    end
`endif

    always_comb begin
        cnt_d     = (en && !tick) ? cnt_q + 1'b1 : '0;
        start_d   = state_q == IDLE && tick;
        state_d   = (state_q == IDLE && tick)         ? START   :
                    (state_q == START)                ? CAPTURE :
                    (state_q == CAPTURE)              ? WAIT_LO :
                    (state_q == WAIT_LO && !adc_busy) ? IDLE    : state_q;
        prime_d   = !en || (prime_q && state_q != CAPTURE);
        valid_d   = load || (valid_q && !out_ready);
        data_d    = load ? word : data_q;
        overrun_d = en && (overrun_q || (tick && state_q != IDLE) || (load && valid_q && !out_ready));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            prime_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            prime_q   <= prime_d;
        end
    end

    assign adc_start = start_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign overrun   = overrun_q;
endmodule
